// File: rtl/seq_gen_pkg.sv
// seq_gen shared types: FSM state encoding and default widths.
package seq_gen_pkg;

    // PARITY is always present so the encoding does not depend on build options.
    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PARITY,
        GAP,
        DONE
    } state_e;

    localparam int unsigned DEF_PATTERN_W  = 4;
    localparam int unsigned DEF_CNT_W      = 4;
    localparam int unsigned DEF_GAP_CYCLES = 1;

endpackage

// File: rtl/seq_gen_if.sv
// seq_gen request/serial-output bundle. master = requester, slave = seq_gen.
interface seq_gen_if
    import seq_gen_pkg::*;
#(
    parameter int unsigned PATTERN_W = DEF_PATTERN_W,
    parameter int unsigned CNT_W     = DEF_CNT_W
);
    logic                 start;
    logic [PATTERN_W-1:0] pattern;
    logic [CNT_W-1:0]     repeat_cnt;
    logic                 abort;
    logic                 o;
    logic                 o_valid;
    logic                 busy;
    logic                 done;

    modport master (
        output start, pattern, repeat_cnt, abort,
        input  o, o_valid, busy, done
    );

    modport slave (
        input  start, pattern, repeat_cnt, abort,
        output o, o_valid, busy, done
    );
endinterface

// File: rtl/seq_gen_piso_sr.sv
// Parallel-load, shift-left register; serial output taken from the MSB.
module piso_sr #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);
    logic [WIDTH-1:0] sr_q;

    // Load wins over shift so a reload on the last bit starts the next repetition cleanly.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else if (shift) begin
            sr_q <= {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    assign sout = sr_q[WIDTH-1];
endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeat_cnt times,
// with GAP_CYCLES idle cycles between repetitions, then pulses done.
// Optional build macro SEQ_GEN_PARITY_EN appends an even-parity bit to each repetition.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned PATTERN_W  = DEF_PATTERN_W,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
    input logic       clk,
    input logic       n_rst,
    seq_gen_if.slave  bus
);
    localparam int unsigned BIT_W = $clog2(PATTERN_W);
    localparam int unsigned GAP_W = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PATTERN_W - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e               state_q, state_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [CNT_W-1:0]     rep_q, rep_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [PATTERN_W-1:0] pat_q, pat_d;
    logic                 sr_load, sr_shift, sr_out, rep_end;
    logic [PATTERN_W-1:0] sr_din;
`ifdef SEQ_GEN_PARITY_EN
    logic                 par_q, par_d;
`endif

    // The very first load comes straight from the bus; later reloads use the captured copy.
    assign sr_din = (state_q == IDLE) ? bus.pattern : pat_q;

    piso_sr #(
        .WIDTH (PATTERN_W)
    ) u_sr (
        .clk   (clk),
        .n_rst (n_rst),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (sr_din),
        .sout  (sr_out)
    );

    // State and counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            pat_q   <= '0;
`ifdef SEQ_GEN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            pat_q   <= pat_d;
`ifdef SEQ_GEN_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state and counter updates; abort overrides everything outside IDLE.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        rep_d    = rep_q;
        gap_d    = gap_q;
        pat_d    = pat_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        rep_end  = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pat_d = bus.pattern;
                    rep_d = bus.repeat_cnt;
`ifdef SEQ_GEN_PARITY_EN
                    par_d = ^bus.pattern;
`endif
                    if (bus.repeat_cnt != '0) begin
                        state_d = SHIFT;
                        sr_load = 1'b1;
                        bit_d   = BIT_LAST;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                sr_shift = 1'b1;
                bit_d    = bit_q - 1'b1;
                if (bit_q == '0) begin
`ifdef SEQ_GEN_PARITY_EN
                    state_d = PARITY;
`else
                    rep_end = 1'b1;
`endif
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            PARITY: rep_end = 1'b1;
`endif
            GAP: begin
                if (gap_q == '0) begin
                    state_d = SHIFT;
                    sr_load = 1'b1;
                    bit_d   = BIT_LAST;
                    rep_d   = rep_q - 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // End of one repetition: finish, wait out the gap, or restart immediately.
        if (rep_end) begin
            if (rep_q == CNT_W'(1)) begin
                state_d = DONE;
            end else if (GAP_CYCLES == 0) begin
                state_d = SHIFT;
                sr_load = 1'b1;
                bit_d   = BIT_LAST;
                rep_d   = rep_q - 1'b1;
            end else begin
                state_d = GAP;
                gap_d   = GAP_LOAD;
            end
        end

        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // Moore outputs decoded from the current state and datapath registers.
    always_comb begin
        bus.o       = 1'b0;
        bus.o_valid = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        unique case (state_q)
            SHIFT: begin
                bus.o       = sr_out;
                bus.o_valid = 1'b1;
                bus.busy    = 1'b1;
            end
`ifdef SEQ_GEN_PARITY_EN
            PARITY: begin
                bus.o       = par_q;
                bus.o_valid = 1'b1;
                bus.busy    = 1'b1;
            end
`endif
            GAP:  bus.busy = 1'b1;
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: two instances (GAP_CYCLES=1 and 0) share one stimulus stream.
// A waveform-queue model predicts {busy,done,o_valid,o} for every cycle of each instance.
module tb_seq_gen;
    localparam int GAP_A = 1;
    localparam int GAP_B = 0;
`ifdef SEQ_GEN_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start_s = 1'b0;
    logic       abort_s = 1'b0;
    logic [3:0] pat_s = 4'b0;
    logic [3:0] rep_s = 4'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_gen_if #(.PATTERN_W(4), .CNT_W(4)) bus_a ();
    seq_gen_if #(.PATTERN_W(4), .CNT_W(4)) bus_b ();

    assign bus_a.start = start_s;      assign bus_b.start = start_s;
    assign bus_a.abort = abort_s;      assign bus_b.abort = abort_s;
    assign bus_a.pattern = pat_s;      assign bus_b.pattern = pat_s;
    assign bus_a.repeat_cnt = rep_s;   assign bus_b.repeat_cnt = rep_s;

    seq_gen #(.PATTERN_W(4), .CNT_W(4), .GAP_CYCLES(GAP_A)) dut_a (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_a)
    );
    seq_gen #(.PATTERN_W(4), .CNT_W(4), .GAP_CYCLES(GAP_B)) dut_b (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_b)
    );

    // ---------------- model: per-instance queue of expected {busy,done,o_valid,o} ----------
    logic [3:0] mq_a[$];
    logic [3:0] mq_b[$];
    logic [3:0] cur[2] = '{4'b0, 4'b0};

    task automatic push(input int i, input logic [3:0] e);
        if (i == 0) mq_a.push_back(e); else mq_b.push_back(e);
    endtask

    function automatic logic [3:0] pop(input int i);
        if (i == 0) return (mq_a.size() > 0) ? mq_a.pop_front() : 4'b0;
        return (mq_b.size() > 0) ? mq_b.pop_front() : 4'b0;
    endfunction

    task automatic build(input int i, input logic [3:0] p, input logic [3:0] r);
        int gap;
        gap = (i == 0) ? GAP_A : GAP_B;
        for (int k = 0; k < int'(r); k++) begin
            for (int b = 3; b >= 0; b--) push(i, {3'b101, p[b]});
            if (PAR) push(i, {3'b101, ^p});
            if (k < int'(r) - 1) for (int g = 0; g < gap; g++) push(i, 4'b1000);
        end
        push(i, 4'b1100);
    endtask

    task automatic step(input int i);
        if (cur[i][3] && abort_s) begin
            if (i == 0) mq_a.delete(); else mq_b.delete();
            cur[i] = 4'b0;
        end else begin
            if (!cur[i][3] && start_s) build(i, pat_s, rep_s);
            cur[i] = pop(i);
        end
    endtask

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mq_a.delete();
            mq_b.delete();
            cur[0] = 4'b0;
            cur[1] = 4'b0;
        end else begin
            step(0);
            step(1);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] outs(input int i);
        if (i == 0) return {bus_a.busy, bus_a.done, bus_a.o_valid, bus_a.o};
        return {bus_b.busy, bus_b.done, bus_b.o_valid, bus_b.o};
    endfunction

    // Every cycle, away from the active edge.
    always @(negedge clk) begin
        check("cycle_a", 16'(outs(0)), 16'(cur[0]));
        check("cycle_b", 16'(outs(1)), 16'(cur[1]));
    end

    logic [15:0] cap_o, cap_v, cap_b, cap_d;

    // Shift in n cycles of outputs of one instance; cycle 1 ends up in the highest used bit.
    task automatic capture(input int i, input int n);
        logic [3:0] s;
        cap_o = '0; cap_v = '0; cap_b = '0; cap_d = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            s = outs(i);
            cap_o = {cap_o[14:0], s[0]};
            cap_v = {cap_v[14:0], s[1]};
            cap_d = {cap_d[14:0], s[2]};
            cap_b = {cap_b[14:0], s[3]};
        end
    endtask

    task automatic pulse_start(input logic [3:0] p, input logic [3:0] r);
        @(negedge clk);
        pat_s = p;
        rep_s = r;
        start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clk);
        check("reset_a", 16'(outs(0)), 16'h0);
        check("reset_b", 16'(outs(1)), 16'h0);
        n_rst = 1'b1;
        idle(2);

        // Reset asserted during the second SHIFT cycle.
        pulse_start(4'b1101, 4'd2);
        @(negedge clk);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("midrst_a", 16'(outs(0)), 16'h0);
        check("midrst_b", 16'(outs(1)), 16'h0);
        idle(2);
        n_rst = 1'b1;
        pulse_start(4'b1101, 4'd2);
        idle(14);

        // pattern 1101, repeat 2.
        pulse_start(4'b1101, 4'd2);
        capture(0, 11);
`ifndef SEQ_GEN_PARITY_EN
        check("r2_o_a",    cap_o, 16'(11'b11010110100));
        check("r2_v_a",    cap_v, 16'(11'b11110111100));
        check("r2_done_a", cap_d, 16'(11'b00000000010));
        check("r2_busy_a", cap_b, 16'(11'b11111111110));
`endif
        idle(4);

        // GAP_CYCLES=0 instance, repeat 3: 12 contiguous bits then done.
        pulse_start(4'b1101, 4'd3);
        capture(1, 14);
`ifndef SEQ_GEN_PARITY_EN
        check("r3_o_b",    cap_o, 16'(14'b11011101110100));
        check("r3_v_b",    cap_v, 16'(14'b11111111111100));
        check("r3_done_b", cap_d, 16'(14'b00000000000010));
        check("r3_busy_b", cap_b, 16'(14'b11111111111110));
`endif
        idle(8);

        // repeat_cnt = 0: done only, for one cycle.
        pulse_start(4'b1111, 4'd0);
        capture(0, 3);
        check("r0_v",    cap_v, 16'(3'b000));
        check("r0_done", cap_d, 16'(3'b100));
        check("r0_busy", cap_b, 16'(3'b100));

        // Abort in GAP with start held; start re-accepted the following cycle.
        pulse_start(4'b1101, 4'd2);
        idle(5);
        check("ab_gap_busy", 16'(bus_a.busy), 16'h1);
        check("ab_gap_vld",  16'(bus_a.o_valid), 16'h0);
        start_s = 1'b1;
        abort_s = 1'b1;
        rep_s = 4'd1;
        @(posedge clk);
        #1 abort_s = 1'b0;
        @(negedge clk);
        check("ab_idle_busy", 16'(bus_a.busy), 16'h0);
        check("ab_idle_done", 16'(bus_a.done), 16'h0);
        @(posedge clk);
        #1 start_s = 1'b0;
        @(negedge clk);
        check("ab_restart", 16'({bus_a.o_valid, bus_a.o}), 16'h3);
        idle(10);

        // Single repetition with a stray start mid-transfer.
        pulse_start(4'b1101, 4'd1);
        @(negedge clk);
        @(negedge clk);
        pat_s = 4'b0000;
        rep_s = 4'd5;
        start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
        capture(0, 5);
`ifdef SEQ_GEN_PARITY_EN
        check("par_o_tail", cap_o, 16'(5'b01100));
        check("par_v_tail", cap_v, 16'(5'b11100));
        check("par_d_tail", cap_d, 16'(5'b00010));
`else
        check("stray_o_tail", cap_o, 16'(5'b01000));
        check("stray_v_tail", cap_v, 16'(5'b11000));
        check("stray_d_tail", cap_d, 16'(5'b00100));
`endif
        idle(6);

        // Further patterns, including the maximum repeat count.
        pulse_start(4'b1010, 4'd3);
        idle(20);
        pulse_start(4'b0110, 4'd15);
        idle(95);
        pulse_start(4'b0001, 4'd1);
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
